trk_disc: RTL and testbench
===========================

Name: trk_disc

Overview:
- Tracking-loop discriminator stage. Runs once per integration dump.
- Takes the six accumulated correlator sums (early, prompt, late; I and Q) and produces a signed 32-bit PLL discriminator and a signed 32-bit DLL discriminator.
- Issues a one-cycle strobe alongside the results.
- Sits directly upstream of the loop-filter stage, which consumes tx_pll_disc, tx_dll_disc and tx_disc_sop as its rx_pll_disc, rx_dll_disc and rx_prn_sop.

Parameters:
- ACC_W, 24, width of each signed correlator accumulation input.
- FRAC_W, 16, number of quotient fraction bits from the divider; one bit per clock.

Ports:
- rx_clk  in  1  the single clock.
- rx_rst  in  1  reset; asynchronous, active-high.
- rx_acc_valid  in  1  one-cycle pulse; the rx_ie..rx_ql inputs are valid in that cycle.
- rx_ie, rx_ip, rx_il  in  ACC_W each  signed in-phase early, prompt and late sums.
- rx_qe, rx_qp, rx_ql  in  ACC_W each  signed quadrature early, prompt and late sums.
- tx_pll_disc  out  32  signed PLL discriminator.
- tx_dll_disc  out  32  signed DLL discriminator, Q0.FRAC_W.
- tx_disc_sop  out  1  one-cycle pulse; both disc outputs update on the same edge.
- tx_busy  out  1  high whenever the FSM is not IDLE.
- tx_drop_cnt  out  8  saturating count of dumps dropped while busy.

Behaviour:
- Reset (async, rx_rst=1): all outputs 0; FSM returns to IDLE; captured operands cleared. Reset mid-operation aborts the dump and emits no sop.
- FSM states: IDLE → MAG → SUM → DIV_D → (DIV_P, only with the optional feature) → OUT → IDLE.
- IDLE:
  - On rx_acc_valid, register all six inputs and go to MAG.
  - rx_acc_valid while not IDLE: the dump is dropped and tx_drop_cnt increments, saturating at 255.
  - A valid arriving on the same edge that OUT returns to IDLE is dropped.
- MAG: envelopes use alpha-max-beta-min:
  - |x| is two's-complement absolute value, ACC_W+1 bits.
  - mag = max(|I|,|Q|) + (min(|I|,|Q|) >> 1).
  - Compute E and L envelopes this way.
- SUM:
  - num = Emag − Lmag, signed, ACC_W+3 bits.
  - den = Emag + Lmag, unsigned, ACC_W+2 bits.
- DIV_D: restoring fractional divide of |num| by den, exactly FRAC_W cycles.
  - Start with r = |num|.
  - Each cycle: r <<= 1; if r ≥ den then r −= den and the quotient bit is 1, else 0.
  - |num| == den naturally yields 2^FRAC_W − 1.
  - Result q = ±quotient, negated if num < 0, sign-extended to 32.
  - den == 0 forces q = 0; the state is still traversed, so latency is fixed.
- PLL (default, Costas sign discriminator):
  - pll = QP if IP ≥ 0, else −QP, sign-extended to 32.
  - Computed in SUM and held until OUT.
- OUT: register tx_pll_disc and tx_dll_disc, pulse tx_disc_sop for one cycle, return to IDLE.
- Latency: tx_disc_sop is high in the cycle after the (FRAC_W+3)th rising edge following the edge that samples rx_acc_valid. That is 19 edges with the defaults; throughput is one dump per 20 cycles.
- Disc outputs hold their values between sops.
- tx_drop_cnt clears only on reset.

Optional Feature:
- Macro: TRK_DISC_PLL_NORM_EN.
- Defined:
  - Adds state DIV_P, FRAC_W cycles, reusing the same divider instance.
  - pll = ±(|QP| / |IP|) in Q0.FRAC_W, sign = sign(QP) XOR sign(IP).
  - If |QP| ≥ |IP|, the magnitude saturates to 2^FRAC_W − 1.
  - If IP == 0, pll = 0.
  - Latency becomes 2·FRAC_W+3 edges (35 with defaults).
- Undefined: Costas sign discriminator as above; no DIV_P state.

Decomposition:
- Shared package trk_pkg holds:
  - FSM state encoding constants;
  - ACC_W/FRAC_W defaults;
  - DROP_CNT_MAX = 255.
- One sub-module, trk_frac_div: the sequential restoring divider.
  - Ports: start pulse, unsigned num/den, done pulse, FRAC_W-bit quotient.
  - Zero-den handling stays in the parent.

Test Plan:
- IE=1000, QE=0, IL=600, QL=0, IP=−500, QP=300 → after 19 edges: sop=1, tx_dll_disc=16384, tx_pll_disc=−300 (feature off).
- IE=600, IL=1000 (Q=0), IP=800, QP=−200 → tx_dll_disc=−16384, tx_pll_disc=−200.
- IE=−300, QE=400 (Emag=550), IL=0, QL=0 → num=den, tx_dll_disc=65535.
- All six inputs 0 → sop still at edge 19, both discs 0.
- Second rx_acc_valid 5 cycles after the first → exactly one sop, tx_drop_cnt=1.
- rx_rst asserted mid-DIV_D, then released → no sop, all outputs 0, next dump processed normally.
- With TRK_DISC_PLL_NORM_EN: IP=1000, QP=−250 → tx_pll_disc=−16384 at edge 35; IP=100, QP=400 → tx_pll_disc=65535.

Source files
------------

// File: rtl/trk_pkg.sv
// Shared definitions for the tracking-loop discriminator: FSM encoding,
// default widths and the drop-counter ceiling.
package trk_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int FRAC_W_DEF = 16;
  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAG   = 3'd1,
    ST_SUM   = 3'd2,
    ST_DIV_D = 3'd3,
    ST_DIV_P = 3'd4,
    ST_OUT   = 3'd5
  } trk_state_e;

endpackage

// File: rtl/trk_disc_if.sv
// Correlator-dump input bus and discriminator result bus of trk_disc.
interface trk_disc_if
  import trk_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
);

  logic                    rx_acc_valid;
  logic signed [ACC_W-1:0] rx_ie;
  logic signed [ACC_W-1:0] rx_ip;
  logic signed [ACC_W-1:0] rx_il;
  logic signed [ACC_W-1:0] rx_qe;
  logic signed [ACC_W-1:0] rx_qp;
  logic signed [ACC_W-1:0] rx_ql;
  logic signed [31:0]      tx_pll_disc;
  logic signed [31:0]      tx_dll_disc;
  logic                    tx_disc_sop;
  logic                    tx_busy;
  logic [7:0]              tx_drop_cnt;

  modport master (
    output rx_acc_valid, rx_ie, rx_ip, rx_il, rx_qe, rx_qp, rx_ql,
    input  tx_pll_disc, tx_dll_disc, tx_disc_sop, tx_busy, tx_drop_cnt
  );

  modport slave (
    input  rx_acc_valid, rx_ie, rx_ip, rx_il, rx_qe, rx_qp, rx_ql,
    output tx_pll_disc, tx_dll_disc, tx_disc_sop, tx_busy, tx_drop_cnt
  );

endinterface

// File: rtl/trk_frac_div.sv
// Sequential restoring fractional divider: FRAC_W quotient bits of num/den,
// one bit per clock; the first bit is produced on the start edge itself.
module trk_frac_div #(
  parameter int DW     = 26,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DW-1:0]     num,
  input  logic [DW-1:0]     den,
  output logic              done,
  output logic [FRAC_W-1:0] quot
);

  localparam int CW = $clog2(FRAC_W + 1);

  logic [DW-1:0]     rem_q, rem_d;
  logic [DW-1:0]     den_q, den_d;
  logic [FRAC_W-1:0] quot_q, quot_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DW-1:0] rem_src;
  logic [DW-1:0] den_src;
  logic [DW:0]   shifted;
  logic          ge;

  always_comb begin
    rem_src = start ? num : rem_q;
    den_src = start ? den : den_q;
    shifted = {rem_src, 1'b0};
    ge      = (shifted >= {1'b0, den_src});

    rem_d  = rem_q;
    den_d  = den_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start) begin
      rem_d  = ge ? DW'(shifted - {1'b0, den_src}) : shifted[DW-1:0];
      den_d  = den;
      quot_d = {{(FRAC_W-1){1'b0}}, ge};
      cnt_d  = CW'(FRAC_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = ge ? DW'(shifted - {1'b0, den_src}) : shifted[DW-1:0];
      quot_d = {quot_q[FRAC_W-2:0], ge};
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign quot = quot_q;

endmodule

// File: rtl/trk_disc.sv
// Tracking-loop discriminator: Costas sign PLL and normalised E-L DLL per dump.
// Define TRK_DISC_PLL_NORM_EN for the normalised QP/IP PLL (extra DIV_P state).
module trk_disc
  import trk_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic       rx_clk,
  input  logic       rx_rst,
  trk_disc_if.slave  bus
);

  localparam int MW = ACC_W + 1;
  localparam int DW = ACC_W + 2;
  localparam int NW = ACC_W + 3;

  function automatic logic [MW-1:0] abs_val(input logic signed [ACC_W-1:0] x);
    logic signed [MW-1:0] xe;
    xe = MW'(x);
    return xe[MW-1] ? MW'(-xe) : MW'(xe);
  endfunction

  // Alpha-max-beta-min envelope: max + min/2.
  function automatic logic [MW-1:0] env_mag(input logic signed [ACC_W-1:0] i,
                                            input logic signed [ACC_W-1:0] q);
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    a = abs_val(i);
    b = abs_val(q);
    return (a >= b) ? (a + (b >> 1)) : (b + (a >> 1));
  endfunction

  trk_state_e state_q, state_d;

  logic signed [ACC_W-1:0] ie_q, ie_d, ip_q, ip_d, il_q, il_d;
  logic signed [ACC_W-1:0] qe_q, qe_d, qp_q, qp_d, ql_q, ql_d;
  logic [MW-1:0]     emag_q, emag_d, lmag_q, lmag_d;
  logic              num_neg_q, num_neg_d, den_zero_q, den_zero_d;
  logic [FRAC_W-1:0] dll_mag_q, dll_mag_d;
  logic [31:0]       tx_pll_q, tx_pll_d, tx_dll_q, tx_dll_d;
  logic              tx_sop_q, tx_sop_d;
  logic [7:0]        drop_q, drop_d;

  logic signed [NW-1:0] num_s;
  logic [DW-1:0]        den_u;
  logic [DW-1:0]        num_abs;
  logic [31:0]          dll_ext;

  logic              div_start, div_done;
  logic [DW-1:0]     div_num, div_den;
  logic [FRAC_W-1:0] div_quot;

`ifdef TRK_DISC_PLL_NORM_EN
  logic          pll_neg_q, pll_neg_d, pll_sat_q, pll_sat_d, ip_zero_q, ip_zero_d;
  logic [MW-1:0] abs_qp, abs_ip;
  logic [FRAC_W-1:0] pll_mag;
  logic [31:0]   pll_ext;

  assign abs_qp  = abs_val(qp_q);
  assign abs_ip  = abs_val(ip_q);
  assign pll_mag = ip_zero_q ? '0 : (pll_sat_q ? '1 : div_quot);
  assign pll_ext = 32'(pll_mag);
`else
  logic [31:0]        pll_q, pll_d;
  logic signed [31:0] qp_ext;
  logic signed [31:0] costas;

  assign qp_ext = 32'(qp_q);
  assign costas = ip_q[ACC_W-1] ? -qp_ext : qp_ext;
`endif

  assign num_s   = $signed({2'b00, emag_q}) - $signed({2'b00, lmag_q});
  assign den_u   = {1'b0, emag_q} + {1'b0, lmag_q};
  assign num_abs = num_s[NW-1] ? DW'(-num_s) : DW'(num_s);
  assign dll_ext = 32'(dll_mag_q);

  trk_frac_div #(
    .DW     (DW),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk   (rx_clk),
    .rst   (rx_rst),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.rx_acc_valid) state_d = ST_MAG;
      ST_MAG:   state_d = ST_SUM;
      ST_SUM:   state_d = ST_DIV_D;
`ifdef TRK_DISC_PLL_NORM_EN
      ST_DIV_D: if (div_done) state_d = ST_DIV_P;
      ST_DIV_P: if (div_done) state_d = ST_OUT;
`else
      ST_DIV_D: if (div_done) state_d = ST_OUT;
`endif
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The DLL divide is launched from SUM so its first bit lands on the SUM exit edge.
  always_comb begin
    div_start = (state_q == ST_SUM);
    div_num   = num_abs;
    div_den   = den_u;
    tx_sop_d  = (state_q == ST_OUT);
`ifdef TRK_DISC_PLL_NORM_EN
    if (state_q == ST_DIV_D && div_done) begin
      div_start = 1'b1;
      div_num   = DW'(abs_qp);
      div_den   = DW'(abs_ip);
    end
`endif
  end

  always_comb begin
    ie_d = ie_q; ip_d = ip_q; il_d = il_q;
    qe_d = qe_q; qp_d = qp_q; ql_d = ql_q;
    emag_d     = emag_q;
    lmag_d     = lmag_q;
    num_neg_d  = num_neg_q;
    den_zero_d = den_zero_q;
    dll_mag_d  = dll_mag_q;
    tx_pll_d   = tx_pll_q;
    tx_dll_d   = tx_dll_q;
    drop_d     = drop_q;
`ifdef TRK_DISC_PLL_NORM_EN
    pll_neg_d = pll_neg_q;
    pll_sat_d = pll_sat_q;
    ip_zero_d = ip_zero_q;
`else
    pll_d = pll_q;
`endif

    if (bus.rx_acc_valid && state_q != ST_IDLE && drop_q != DROP_CNT_MAX)
      drop_d = drop_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_acc_valid) begin
          ie_d = bus.rx_ie; ip_d = bus.rx_ip; il_d = bus.rx_il;
          qe_d = bus.rx_qe; qp_d = bus.rx_qp; ql_d = bus.rx_ql;
        end
      end
      ST_MAG: begin
        emag_d = env_mag(ie_q, qe_q);
        lmag_d = env_mag(il_q, ql_q);
      end
      ST_SUM: begin
        num_neg_d  = num_s[NW-1];
        den_zero_d = (den_u == '0);
`ifdef TRK_DISC_PLL_NORM_EN
        pll_neg_d = qp_q[ACC_W-1] ^ ip_q[ACC_W-1];
        pll_sat_d = (abs_qp >= abs_ip);
        ip_zero_d = (ip_q == '0);
`else
        pll_d = costas;
`endif
      end
      ST_DIV_D: begin
        if (div_done) dll_mag_d = div_quot;
      end
      ST_OUT: begin
        tx_dll_d = den_zero_q ? '0 : (num_neg_q ? -dll_ext : dll_ext);
`ifdef TRK_DISC_PLL_NORM_EN
        tx_pll_d = pll_neg_q ? -pll_ext : pll_ext;
`else
        tx_pll_d = pll_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      ie_q <= '0; ip_q <= '0; il_q <= '0;
      qe_q <= '0; qp_q <= '0; ql_q <= '0;
      emag_q     <= '0;
      lmag_q     <= '0;
      num_neg_q  <= 1'b0;
      den_zero_q <= 1'b0;
      dll_mag_q  <= '0;
      tx_pll_q   <= '0;
      tx_dll_q   <= '0;
      tx_sop_q   <= 1'b0;
      drop_q     <= '0;
`ifdef TRK_DISC_PLL_NORM_EN
      pll_neg_q <= 1'b0;
      pll_sat_q <= 1'b0;
      ip_zero_q <= 1'b0;
`else
      pll_q <= '0;
`endif
    end else begin
      ie_q <= ie_d; ip_q <= ip_d; il_q <= il_d;
      qe_q <= qe_d; qp_q <= qp_d; ql_q <= ql_d;
      emag_q     <= emag_d;
      lmag_q     <= lmag_d;
      num_neg_q  <= num_neg_d;
      den_zero_q <= den_zero_d;
      dll_mag_q  <= dll_mag_d;
      tx_pll_q   <= tx_pll_d;
      tx_dll_q   <= tx_dll_d;
      tx_sop_q   <= tx_sop_d;
      drop_q     <= drop_d;
`ifdef TRK_DISC_PLL_NORM_EN
      pll_neg_q <= pll_neg_d;
      pll_sat_q <= pll_sat_d;
      ip_zero_q <= ip_zero_d;
`else
      pll_q <= pll_d;
`endif
    end
  end

  assign bus.tx_pll_disc = tx_pll_q;
  assign bus.tx_dll_disc = tx_dll_q;
  assign bus.tx_disc_sop = tx_sop_q;
  assign bus.tx_busy     = (state_q != ST_IDLE);
  assign bus.tx_drop_cnt = drop_q;

endmodule

// File: tb/tb_trk_disc.sv
// Scoreboard bench for trk_disc: stimulus pushes model results, a monitor
// pops and compares on each sop. Honours TRK_DISC_PLL_NORM_EN.
module tb_trk_disc;

  localparam int ACC_W  = 24;
  localparam int FRAC_W = 16;
`ifdef TRK_DISC_PLL_NORM_EN
  localparam int LAT = 2 * FRAC_W + 3;
`else
  localparam int LAT = FRAC_W + 3;
`endif

  typedef struct {
    longint pll;
    longint dll;
    int     sop_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   last_e = -1000;
  int   exp_drop = 0;
  exp_t sb[$];
  exp_t item;
  bit   busy_exp;

  trk_disc_if #(.ACC_W(ACC_W)) bus();

  trk_disc #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .rx_clk (clk),
    .rx_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint absl(longint x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic longint env_m(longint i, longint q);
    longint a;
    longint b;
    a = absl(i);
    b = absl(q);
    return (a > b) ? (a + b / 2) : (b + a / 2);
  endfunction

  // Fractional quotient n/d in Q0.FRAC_W, saturating at all-ones.
  function automatic longint frac_m(longint n, longint d);
    longint r;
    if (d == 0)      r = 0;
    else if (n >= d) r = (longint'(1) << FRAC_W) - 1;
    else             r = (n << FRAC_W) / d;
    return r;
  endfunction

  function automatic longint dll_m(longint ie, longint qe, longint il, longint ql);
    longint num;
    longint m;
    num = env_m(ie, qe) - env_m(il, ql);
    m   = frac_m(absl(num), env_m(ie, qe) + env_m(il, ql));
    return (num < 0) ? -m : m;
  endfunction

  function automatic longint pll_m(longint ip, longint qp);
    longint r;
`ifdef TRK_DISC_PLL_NORM_EN
    longint m;
    m = frac_m(absl(qp), absl(ip));
    if (ip == 0)                     r = 0;
    else if ((qp < 0) != (ip < 0))   r = -m;
    else                             r = m;
`else
    r = (ip >= 0) ? qp : -qp;
`endif
    return r;
  endfunction

  function automatic longint rand_acc();
    logic signed [ACC_W-1:0] v;
    longint r;
    case ($urandom_range(0, 4))
      0: r = longint'($urandom_range(0, 100)) - 50;
      1: begin v = ACC_W'($urandom); r = longint'(v); end
      2: r = ($urandom_range(0, 1) != 0) ? longint'(2**(ACC_W-1) - 1) : -longint'(2**(ACC_W-1));
      3: r = longint'($urandom_range(0, 4000)) - 2000;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input longint ie, input longint qe, input longint il,
                               input longint ql, input longint ip, input longint qp);
    exp_t x;
    int   e;
    @(negedge clk);
    bus.rx_ie = ACC_W'(ie); bus.rx_qe = ACC_W'(qe);
    bus.rx_il = ACC_W'(il); bus.rx_ql = ACC_W'(ql);
    bus.rx_ip = ACC_W'(ip); bus.rx_qp = ACC_W'(qp);
    bus.rx_acc_valid = 1'b1;
    e = cyc + 1;
    if (e >= last_e + LAT + 1) begin
      x.pll     = pll_m(ip, qp);
      x.dll     = dll_m(ie, qe, il, ql);
      x.sop_cyc = e + LAT;
      sb.push_back(x);
      last_e = e;
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
    @(negedge clk);
    bus.rx_acc_valid = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pll"},  longint'($signed(bus.tx_pll_disc)), 0);
    checkOutput({tag, "_dll"},  longint'($signed(bus.tx_dll_disc)), 0);
    checkOutput({tag, "_sop"},  longint'(bus.tx_disc_sop), 0);
    checkOutput({tag, "_busy"}, longint'(bus.tx_busy), 0);
    checkOutput({tag, "_drop"}, longint'(bus.tx_drop_cnt), 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    last_e   = -1000;
    exp_drop = 0;
    @(posedge clk);
    #1;
    checkResetState("midrst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: per-cycle busy/drop checks and scoreboard pops on sop.
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      busy_exp = (cyc >= last_e) && (cyc <= last_e + LAT - 1);
      checkOutput("busy", longint'(bus.tx_busy), longint'(busy_exp));
      checkOutput("drop_cnt", longint'(bus.tx_drop_cnt), longint'(exp_drop));
      if (bus.tx_disc_sop) begin
        if (sb.size() == 0) begin
          checkOutput("sop_unexpected", longint'(cyc), -1);
        end else if (sb[0].sop_cyc != cyc) begin
          checkOutput("sop_cycle", longint'(cyc), longint'(sb[0].sop_cyc));
        end else begin
          item = sb.pop_front();
          checkOutput("sop_cycle", longint'(cyc), longint'(item.sop_cyc));
          checkOutput("pll_disc", longint'($signed(bus.tx_pll_disc)), item.pll);
          checkOutput("dll_disc", longint'($signed(bus.tx_dll_disc)), item.dll);
        end
      end else if (sb.size() != 0 && sb[0].sop_cyc <= cyc) begin
        item = sb.pop_front();
        checkOutput("sop_missing", -1, longint'(item.sop_cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.rx_acc_valid = 1'b0;
    bus.rx_ie = '0; bus.rx_ip = '0; bus.rx_il = '0;
    bus.rx_qe = '0; bus.rx_qp = '0; bus.rx_ql = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed dumps");
    applyStimulus(1000, 0, 600, 0, -500, 300);
    repeat (LAT + 2) @(negedge clk);
    applyStimulus(600, 0, 1000, 0, 800, -200);
    repeat (LAT + 2) @(negedge clk);
    applyStimulus(-300, 400, 0, 0, 0, 0);
    repeat (LAT + 2) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (LAT + 2) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1000, -250);
    repeat (LAT + 2) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 100, 400);
    repeat (LAT + 2) @(negedge clk);

    $display("[TB] dump arriving while busy");
    applyStimulus(500, -200, 100, 50, -7, 9);
    repeat (3) @(negedge clk);
    applyStimulus(1, 2, 3, 4, 5, 6);
    repeat (LAT + 2) @(negedge clk);

    $display("[TB] reset during the DLL divide");
    applyStimulus(12345, -678, 910, 1112, 1314, -1516);
    repeat (8) @(negedge clk);
    pulseReset();
    repeat (LAT + 2) @(negedge clk);
    applyStimulus(1000, 0, 600, 0, -500, 300);
    repeat (LAT + 2) @(negedge clk);

    $display("[TB] randomized dumps");
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, LAT + 6)) @(negedge clk);
      applyStimulus(rand_acc(), rand_acc(), rand_acc(), rand_acc(), rand_acc(), rand_acc());
    end

    repeat (LAT + 4) @(negedge clk);
    checkOutput("queue_drained", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
